fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Control FSM that sequences instruction fetch for the processor datapath: moves PC into the address register, performs a memory read handshake, loads the data register, then pulses `LDIR` so the instruction register captures the opcode. It then dispatches to the execute unit and waits for completion. It also detects a halt opcode, supervises memory acknowledge with a watchdog, and counts retired instructions. It sits between the memory interface, the PC/AR/DR/IR registers and the execute sequencer.

## Interface
- `INSTRUCTION_LEN`, 6: opcode width (low bits of data word)
- `DATA_LEN`, 16: memory data width; also `instr_count` width
- `HALT_OPCODE`, 6'h3F: opcode that stops the sequencer
- `ACK_TIMEOUT`, 15: max cycles in FETCH_REQ without `mem_ack` before fault (≥2)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  leave IDLE/HALTED and begin fetching
- `mem_req`  out  1  memory read request
- `mem_ack`  in  1  memory read complete; `mem_rdata` valid same cycle
- `mem_rdata`  in  DATA_LEN  memory read data
- `LDAR`  out  1  load AR from PC
- `INCPC`  out  1  increment PC
- `LDDR`  out  1  load DR from memory
- `LDIR`  out  1  load IR from DR
- `ir_opcode`  out  INSTRUCTION_LEN  shadow copy of fetched opcode
- `exec_start`  out  1  one-cycle pulse, start execute
- `exec_done`  in  1  execute finished
- `halted`  out  1  sequencer in HALTED
- `fault`  out  1  memory ack timeout, sticky
- `instr_count`  out  DATA_LEN  dispatched instruction count

## Operation
- States: IDLE, FETCH_AR, FETCH_REQ, FETCH_DR, FETCH_IR, DISPATCH, EXEC, HALTED, FAULT.
- IDLE: `start`=1 → FETCH_AR.
- FETCH_AR: `LDAR`=1 → FETCH_REQ.
- FETCH_REQ: `mem_req`=1. On `mem_ack`=1, capture `mem_rdata[INSTRUCTION_LEN-1:0]` into `ir_opcode` → FETCH_DR. Otherwise the watchdog increments; at `ACK_TIMEOUT` cycles without ack → FAULT.
- FETCH_DR: `LDDR`=1, `INCPC`=1 → FETCH_IR.
- FETCH_IR: `LDIR`=1 → DISPATCH.
- DISPATCH: if `ir_opcode`==`HALT_OPCODE` → HALTED (no `exec_start`, no count). Else `exec_start`=1, `instr_count` += 1 (wraps at 2^DATA_LEN) → EXEC.
- EXEC: `exec_done`=1 → FETCH_AR.
- HALTED: `halted`=1. `start`=1 → FETCH_AR. `instr_count` is held.
- FAULT: `fault`=1. Only `rst_n` exits.
- Control strobes `LDAR`/`INCPC`/`LDDR`/`LDIR`/`mem_req`/`exec_start` are Moore outputs, each high only in its state and mutually exclusive.
- `mem_ack` outside FETCH_REQ, `exec_done` outside EXEC, and `start` outside IDLE/HALTED are ignored.
- Simultaneous events:
  - `mem_ack` in the cycle the watchdog reaches its limit: ack wins, no fault.
  - `start` and `exec_done` together in EXEC: `exec_done` governs.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE; all strobes 0; `ir_opcode`=0; `instr_count`=0; `halted`=0; `fault`=0; watchdog=0.
- Reset mid-fetch or mid-exec aborts immediately. There is no completion of an in-flight request.
- `start` sampled high at edge N → `LDAR` high in cycle N+1.
- With zero-wait ack: `mem_req` in N+2, `LDDR`/`INCPC` in N+3, `LDIR` in N+4, `exec_start` in N+5.
- Each wait cycle on `mem_ack` adds one cycle.
- `exec_done` sampled at edge M → `LDAR` in cycle M+1. Minimum instruction period is 6 cycles.
- Watchdog clears on entry to FETCH_REQ. FAULT is entered at the edge ending the `ACK_TIMEOUT`-th consecutive no-ack cycle.
- `ir_opcode` updates at the ack edge and is stable through DISPATCH/EXEC.

## Structure
- Package `fetch_seq_pkg`:
  - state enum (9 states, binary encoded)
  - default `HALT_OPCODE`
  - watchdog width function `$clog2(ACK_TIMEOUT+1)`
- Sub-module `ack_watchdog`:
  - inputs: clear, enable
  - output: expired
  - counts enabled cycles to `ACK_TIMEOUT`, saturates
- Everything else lives in one FSM module: state register, next-state logic, output decode, `ir_opcode` and `instr_count` registers.

## Test plan
- Reset, `start` pulse, `mem_ack` on the first request cycle with `mem_rdata`=16'h0005, `exec_done` 2 cycles after `exec_start`:
  - strobes in exact order LDAR, REQ, LDDR+INCPC, LDIR, `exec_start`
  - `ir_opcode`=5, `instr_count`=1
- Ack delayed 3 cycles: `mem_req` held exactly 4 cycles; `exec_start` 3 cycles later than the zero-wait case.
- `mem_rdata`=16'h003F:
  - HALTED with `halted`=1, no `exec_start`, `instr_count` unchanged
  - `start` → `LDAR` next cycle
- No ack for 15 cycles: `fault`=1 from then on, `mem_req`=0. Ack at cycle 15 exactly: no fault.
- Assert `rst_n`=0 during FETCH_REQ and during EXEC: all outputs 0 asynchronously, `instr_count`=0. Restart fetches normally.
- Preload `instr_count` to 16'hFFFF via 65535 short instructions (or force): the next dispatch wraps to 0.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// Shared types and helpers for the instruction fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_AR,
    S_FETCH_REQ,
    S_FETCH_DR,
    S_FETCH_IR,
    S_DISPATCH,
    S_EXEC,
    S_HALTED,
    S_FAULT
  } state_e;

  localparam logic [5:0] HALT_OPCODE_DEF = 6'h3F;

  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/ack_watchdog.sv
// Counts consecutive enabled (no-ack) cycles; expired marks the cycle that
// would complete ACK_TIMEOUT of them.
module ack_watchdog
  import fetch_seq_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = wd_width(ACK_TIMEOUT);
  localparam logic [W-1:0] LIMIT = W'(ACK_TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // high while the current no-ack cycle is the last one allowed
  assign expired = enable && (cnt_q >= (LIMIT - 1'b1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/dispatch control FSM: PC->AR, memory read, DR, IR, execute handshake,
// halt detection, ack watchdog and retired-instruction count.
//   state       | meaning
//   S_IDLE      | waiting for start after reset
//   S_FETCH_AR  | LDAR, arm watchdog
//   S_FETCH_REQ | mem_req until mem_ack or timeout
//   S_FETCH_DR  | LDDR + INCPC
//   S_FETCH_IR  | LDIR
//   S_DISPATCH  | halt check, exec_start + count
//   S_EXEC      | wait for exec_done
//   S_HALTED    | halt opcode seen, wait for start
//   S_FAULT     | ack timeout, only reset exits
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int                         INSTRUCTION_LEN = 6,
  parameter int                         DATA_LEN        = 16,
  parameter logic [INSTRUCTION_LEN-1:0] HALT_OPCODE     = HALT_OPCODE_DEF,
  parameter int                         ACK_TIMEOUT     = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       mem_req,
  input  logic                       mem_ack,
  input  logic [DATA_LEN-1:0]        mem_rdata,
  output logic                       LDAR,
  output logic                       INCPC,
  output logic                       LDDR,
  output logic                       LDIR,
  output logic [INSTRUCTION_LEN-1:0] ir_opcode,
  output logic                       exec_start,
  input  logic                       exec_done,
  output logic                       halted,
  output logic                       fault,
  output logic [DATA_LEN-1:0]        instr_count
);

  state_e                       state_q, state_d;
  logic [INSTRUCTION_LEN-1:0]   opcode_q, opcode_d;
  logic [DATA_LEN-1:0]          count_q, count_d;
  logic                         wd_clear, wd_enable, wd_expired;
  logic                         unused_rdata;

  assign unused_rdata = ^mem_rdata[DATA_LEN-1:INSTRUCTION_LEN];

  ack_watchdog #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    count_d    = count_q;
    wd_clear   = 1'b0;
    wd_enable  = 1'b0;
    LDAR       = 1'b0;
    mem_req    = 1'b0;
    LDDR       = 1'b0;
    INCPC      = 1'b0;
    LDIR       = 1'b0;
    exec_start = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH_AR;
      S_FETCH_AR: begin
        LDAR     = 1'b1;
        wd_clear = 1'b1;
        state_d  = S_FETCH_REQ;
      end
      S_FETCH_REQ: begin
        mem_req   = 1'b1;
        wd_enable = !mem_ack;
        // ack takes priority over a watchdog expiring in the same cycle
        if (mem_ack) begin
          opcode_d = mem_rdata[INSTRUCTION_LEN-1:0];
          state_d  = S_FETCH_DR;
        end else if (wd_expired) begin
          state_d  = S_FAULT;
        end
      end
      S_FETCH_DR: begin
        LDDR    = 1'b1;
        INCPC   = 1'b1;
        state_d = S_FETCH_IR;
      end
      S_FETCH_IR: begin
        LDIR    = 1'b1;
        state_d = S_DISPATCH;
      end
      S_DISPATCH: begin
        if (opcode_q == HALT_OPCODE) begin
          state_d = S_HALTED;
        end else begin
          exec_start = 1'b1;
          count_d    = count_q + 1'b1;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: if (exec_done) state_d = S_FETCH_AR;
      S_HALTED: begin
        halted = 1'b1;
        if (start) state_d = S_FETCH_AR;
      end
      S_FAULT: fault = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      count_q  <= count_d;
    end
  end

  assign ir_opcode   = opcode_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized transaction-level bench for fetch_sequencer plus a narrow-count
// instance used to reach the instruction counter wrap quickly.
module tb_fetch_sequencer;

  localparam int AT = 15;
  localparam logic [7:0] E_LDAR  = 8'h80;
  localparam logic [7:0] E_REQ   = 8'h40;
  localparam logic [7:0] E_LDDR  = 8'h20;
  localparam logic [7:0] E_INC   = 8'h10;
  localparam logic [7:0] E_LDIR  = 8'h08;
  localparam logic [7:0] E_XS    = 8'h04;
  localparam logic [7:0] E_HALT  = 8'h02;
  localparam logic [7:0] E_FAULT = 8'h01;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mem_ack = 1'b0;
  logic        exec_done = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_req, LDAR, INCPC, LDDR, LDIR, exec_start, halted, fault;
  logic [5:0]  ir_opcode;
  logic [15:0] instr_count;
  logic [7:0]  obs;

  logic        w_rst_n = 1'b0;
  logic        w_start = 1'b0;
  logic        w_one = 1'b1;
  logic [7:0]  w_rdata = 8'h01;
  logic        w_mem_req, w_LDAR, w_INCPC, w_LDDR, w_LDIR, w_exec_start, w_halted, w_fault;
  logic [5:0]  w_ir_opcode;
  logic [7:0]  w_instr_count;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] model_cnt = '0;
  bit          need_start = 1'b1;
  bit          faulted = 1'b0;

  always #5 clk = ~clk;

  fetch_sequencer #(.INSTRUCTION_LEN(6), .DATA_LEN(16), .HALT_OPCODE(6'h3F), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .LDAR(LDAR), .INCPC(INCPC), .LDDR(LDDR), .LDIR(LDIR),
    .ir_opcode(ir_opcode), .exec_start(exec_start), .exec_done(exec_done),
    .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  fetch_sequencer #(.INSTRUCTION_LEN(6), .DATA_LEN(8), .HALT_OPCODE(6'h3F), .ACK_TIMEOUT(AT)) dut_w (
    .clk(clk), .rst_n(w_rst_n), .start(w_start), .mem_req(w_mem_req), .mem_ack(w_one),
    .mem_rdata(w_rdata), .LDAR(w_LDAR), .INCPC(w_INCPC), .LDDR(w_LDDR), .LDIR(w_LDIR),
    .ir_opcode(w_ir_opcode), .exec_start(w_exec_start), .exec_done(w_one),
    .halted(w_halted), .fault(w_fault), .instr_count(w_instr_count)
  );

  assign obs = {LDAR, mem_req, LDDR, INCPC, LDIR, exec_start, halted, fault};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check_eq(tag, {24'd0, obs}, {24'd0, exp});
  endtask

  task automatic noise();
    start     = 1'($urandom);
    mem_ack   = 1'($urandom);
    exec_done = 1'($urandom);
    mem_rdata = 16'($urandom);
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_strobes", {24'd0, obs}, 32'd0);
    check_eq("rst_opcode", {26'd0, ir_opcode}, 32'd0);
    check_eq("rst_count", {16'd0, instr_count}, 32'd0);
    start = 1'b0; mem_ack = 1'b0; exec_done = 1'b0;
    model_cnt = '0; need_start = 1'b1; faulted = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("idle_after_rst", 8'h00);
  endtask

  // one instruction: ack after d wait cycles, exec_done on the e-th exec cycle
  task automatic do_instr(input int d, input logic [15:0] rd, input int e);
    if (need_start) begin
      start = 1'b1; mem_ack = 1'($urandom); exec_done = 1'($urandom);
    end
    step("ldar", E_LDAR);
    noise();
    for (int i = 0; i < AT; i++) begin
      step("req", E_REQ);
      if (i == d) begin
        mem_ack = 1'b1; mem_rdata = rd;
        break;
      end
      mem_ack = 1'b0; mem_rdata = 16'($urandom);
      start = 1'($urandom); exec_done = 1'($urandom);
    end
    if (d >= AT) begin
      for (int k = 0; k < 3; k++) begin
        step("fault", E_FAULT);
        noise();
      end
      check_eq("fault_cnt", {16'd0, instr_count}, {16'd0, model_cnt});
      faulted = 1'b1;
      return;
    end
    step("dr", E_LDDR | E_INC);
    check_eq("opcode_dr", {26'd0, ir_opcode}, {26'd0, rd[5:0]});
    noise();
    step("ir", E_LDIR);
    noise();
    if (rd[5:0] == 6'h3F) begin
      step("disp_halt", 8'h00);
      noise();
      step("halt", E_HALT);
      start = 1'b0;
      check_eq("halt_cnt", {16'd0, instr_count}, {16'd0, model_cnt});
      need_start = 1'b1;
      return;
    end
    model_cnt = model_cnt + 16'd1;
    step("disp", E_XS);
    noise();
    for (int j = 0; j <= e; j++) begin
      step("exec", 8'h00);
      check_eq("opcode_exec", {26'd0, ir_opcode}, {26'd0, rd[5:0]});
      if (j == 0) check_eq("count", {16'd0, instr_count}, {16'd0, model_cnt});
      exec_done = (j == e);
      start     = 1'($urandom);
      mem_ack   = 1'($urandom);
    end
    need_start = 1'b0;
  endtask

  initial begin
    int n;
    int d;
    logic [15:0] rd;

    @(negedge clk);
    @(negedge clk);
    check_eq("reset_strobes", {24'd0, obs}, 32'd0);
    check_eq("reset_opcode", {26'd0, ir_opcode}, 32'd0);
    check_eq("reset_count", {16'd0, instr_count}, 32'd0);
    rst_n = 1'b1;
    step("idle", 8'h00);
    repeat (2) begin
      mem_ack = 1'b1; exec_done = 1'b1;
      step("idle_hold", 8'h00);
    end

    do_instr(0, 16'h0005, 1);
    check_eq("first_opcode", {26'd0, ir_opcode}, 32'd5);
    check_eq("first_count", {16'd0, instr_count}, 32'd1);
    do_instr(3, 16'h1207, 0);
    do_instr(0, 16'h003F, 0);
    repeat (2) step("halt_hold", E_HALT);
    do_instr(0, 16'h0011, 2);
    do_instr(AT, 16'h0000, 0);
    apply_reset();
    do_instr(AT - 1, 16'h0022, 0);

    // reset during FETCH_REQ
    step("rq_ldar", E_LDAR);
    start = 1'b0; mem_ack = 1'b0;
    step("rq_req", E_REQ);
    step("rq_req2", E_REQ);
    apply_reset();

    // reset during EXEC
    start = 1'b1;
    step("rx_ldar", E_LDAR);
    start = 1'b0;
    step("rx_req", E_REQ);
    mem_ack = 1'b1; mem_rdata = 16'h0009;
    step("rx_dr", E_LDDR | E_INC);
    mem_ack = 1'b0;
    step("rx_ir", E_LDIR);
    step("rx_disp", E_XS);
    exec_done = 1'b0;
    step("rx_exec", 8'h00);
    check_eq("rx_count", {16'd0, instr_count}, 32'd1);
    apply_reset();
    do_instr(0, 16'h0002, 0);
    check_eq("restart_count", {16'd0, instr_count}, 32'd1);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: d = int'($urandom_range(0, 2));
        6, 7:             d = int'($urandom_range(3, 14));
        8:                d = AT - 1;
        default:          d = int'($urandom_range(AT, AT + 2));
      endcase
      rd = 16'($urandom);
      if ($urandom_range(0, 5) == 0) rd[5:0] = 6'h3F;
      else if (rd[5:0] == 6'h3F) rd[0] = 1'b0;
      do_instr(d, rd, int'($urandom_range(0, 3)));
      if (faulted) apply_reset();
      else if (need_start) begin
        repeat ($urandom_range(0, 2)) step("rand_halt_hold", E_HALT);
      end
    end

    // counter wrap on the 8-bit instance
    @(negedge clk);
    w_rst_n = 1'b1;
    @(negedge clk);
    w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    n = 1;
    while (w_instr_count != 8'hFF && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("wrap_reach_ff", n, 6 * 255);
    n = 0;
    while (!w_exec_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("wrap_dispatch_gap", n, 5);
    @(negedge clk);
    check_eq("wrap_zero", {24'd0, w_instr_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
